result_checker: RTL and testbench
=================================

Name: result_checker

Overview:
- Synthesizable checker that sits directly downstream of the core's data-memory request port.
- It snoops store traffic and captures each word written to the result mailbox address into a small FIFO.
- Each captured word is compared, in order, against an expected-answer table, and the block keeps pass/fail counts.
- It raises done when NUM_TESTS results have been checked or when the timeout expires. This moves the pass/fail decision on-chip, so benches and FPGA builds only read status.

Parameters:
- ADDR_W, 32, width of the snooped address.
- DATA_W, 32, width of the result data.
- RESULT_ADDR, 32'h800010d0, mailbox address whose stores count as results.
- NUM_TESTS, 16, number of expected answers. Range 1..256.
- FIFO_DEPTH, 4, capture FIFO entries. Must be a power of 2, at least 2.
- TIMEOUT, 1000, maximum number of cycles between consecutive result captures while ACTIVE.

Ports:
- clock, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, one-cycle pulse that begins checking.
- ans_we, input, 1, write strobe for the expected-answer table.
- ans_idx, input, 8, index into the answer table.
- ans_data, input, DATA_W, expected answer value.
- mon_valid, input, 1, data-memory request fires this cycle.
- mon_wen, input, 1, the request is a store.
- mon_addr, input, ADDR_W, request address.
- mon_wdata, input, DATA_W, store data.
- busy, output, 1, high while in the ACTIVE state.
- done, output, 1, high while in the DONE state.
- timeout, output, 1, sticky flag: the run ended by timeout.
- overflow, output, 1, sticky flag: a capture was dropped because the FIFO was full.
- pass_count, output, 9, number of results that matched.
- fail_count, output, 9, number of results that mismatched.
- cmp_valid, output, 1, one-cycle pulse per compared result.
- cmp_pass, output, 1, match result for that comparison.
- cmp_idx, output, 8, test index for that comparison.
- cmp_expected, output, DATA_W, expected value for that comparison.
- cmp_actual, output, DATA_W, captured value for that comparison.

Behaviour:
- Reset values: all outputs are 0, the FIFO is empty, the state is IDLE, and the test index is 0. The answer table is not reset; its contents are undefined until written.
- Reset is asynchronous. Asserting it mid-run aborts immediately, and no partial counts are retained.
- States:
  - IDLE to ACTIVE on start. On this transition: clear pass_count, fail_count, timeout, overflow, the FIFO, the test index and the timeout counter.
  - ACTIVE to DONE when the test index reaches NUM_TESTS, on the cycle after the last comparison.
  - ACTIVE to DONE when the timeout counter reaches TIMEOUT; timeout is set on the same edge.
  - DONE to ACTIVE on start, with the same clears as above. DONE is otherwise a hold state.
  - start is ignored while ACTIVE.
- Answer table:
  - Written only in IDLE or DONE, when ans_we is high and ans_idx < NUM_TESTS.
  - Otherwise the write is ignored, including while ACTIVE.
- Capture:
  - A capture occurs when mon_valid, mon_wen and mon_addr == RESULT_ADDR are all high, with an exact compare.
  - It is pushed only while ACTIVE and only while the test index plus the FIFO occupancy is less than NUM_TESTS. Excess results are ignored without setting overflow.
  - If the FIFO is full and no pop occurs this cycle, the capture is dropped and overflow is set.
  - A push and a pop in the same cycle on a full FIFO are both accepted.
  - Captures in IDLE or DONE are ignored.
- Compare:
  - While ACTIVE and the FIFO is non-empty, pop one entry per cycle.
  - On the next edge: pulse cmp_valid, present cmp_idx (the test index) and cmp_expected (table[test index]) with cmp_actual, and increment pass_count or fail_count. Then increment the test index.
  - Total latency from capture edge to the cmp_valid edge is 2 cycles when the FIFO is empty.
- Timeout counter:
  - Counts cycles while ACTIVE.
  - Clears on every accepted push.
  - Saturates at TIMEOUT.
- Counter widths: pass_count + fail_count never exceeds NUM_TESTS, so no wrap is possible.
- cmp_* outputs hold their last values between pulses. Only cmp_valid pulses.

Test Plan:
- Load answers 0,1,1,2 with NUM_TESTS=4, then start. Store those values to 0x800010d0, spaced 5 cycles apart. Required: four cmp_pass=1 pulses with cmp_idx 0..3, pass_count=4, fail_count=0, and done asserts 1 cycle after the 4th cmp_valid.
- Store the same values, but make the 3rd store 0xDEADBEEF. Required: cmp_pass=0 at idx 2 with cmp_expected=1 and cmp_actual=0xDEADBEEF, pass_count=3, fail_count=1.
- With FIFO_DEPTH=4, issue 6 back-to-back result stores starting the cycle after start. Required: the FIFO drains concurrently, so there is no overflow and all 4 tests are compared. Extra stores beyond NUM_TESTS are ignored without setting overflow.
- Interleave loads to RESULT_ADDR and stores to 0x800010d4. Required: no captures occur, and timeout asserts TIMEOUT cycles after start with done=1 and pass_count=0.
- Assert reset mid-run after 2 comparisons. Required: all outputs are 0 immediately and the state is IDLE. A new start then completes a full run correctly.
- Hold ans_we during ACTIVE with ans_idx=0 and ans_data=0x55. Required: the table is unchanged and comparison 0 still uses the original expected value.

Source files
------------

// File: rtl/result_checker.sv
// ---------------------------------------------------------------------------
// result_checker
//   Snoops the core's data-memory request port and captures every store to the
//   result mailbox address into a small FIFO. The captured words are compared in
//   order against an expected-answer table. Pass/fail counts are kept on-chip,
//   so benches and FPGA builds only need to read the status outputs.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-low reset
//   start        : one-cycle pulse, begins a run from IDLE or DONE
//   ans_we/idx/data : expected-answer table write port (IDLE/DONE only)
//   mon_valid/wen/addr/wdata : snooped data-memory request
//   busy / done  : run in progress / run finished
//   timeout      : sticky, the run ended because no result arrived in time
//   overflow     : sticky, a capture was dropped on a full FIFO
//   pass_count / fail_count : results that matched / mismatched
//   cmp_valid    : one-cycle pulse per compared result
//   cmp_pass/idx/expected/actual : details of the latest comparison (held)
// ---------------------------------------------------------------------------
module result_checker #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] RESULT_ADDR = 32'h800010d0,
   parameter int                NUM_TESTS   = 16,
   parameter int                FIFO_DEPTH  = 4,
   parameter int                TIMEOUT     = 1000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              ans_we,
   input  logic [7:0]        ans_idx,
   input  logic [DATA_W-1:0] ans_data,
   input  logic              mon_valid,
   input  logic              mon_wen,
   input  logic [ADDR_W-1:0] mon_addr,
   input  logic [DATA_W-1:0] mon_wdata,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic              overflow,
   output logic [8:0]        pass_count,
   output logic [8:0]        fail_count,
   output logic              cmp_valid,
   output logic              cmp_pass,
   output logic [7:0]        cmp_idx,
   output logic [DATA_W-1:0] cmp_expected,
   output logic [DATA_W-1:0] cmp_actual
);

   localparam int IDX_W     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
   localparam int TBL_DEPTH = 1 << IDX_W;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int TMO_W     = $clog2(TIMEOUT + 1);

   localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   PTR_ONE       = (PTR_W+1)'(1);
   localparam logic [TMO_W-1:0] TMO_MAX       = TMO_W'(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST      = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE       = TMO_W'(1);
   localparam logic [8:0]       NUM_TESTS_9   = 9'(NUM_TESTS);
   localparam logic [9:0]       NUM_TESTS_10  = 10'(NUM_TESTS);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t            state, state_nxt;

   logic [DATA_W-1:0] ans_tbl  [TBL_DEPTH];
   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr, fifo_cnt;
   logic              fifo_empty, fifo_full;

   // Popped entry waiting one cycle for its comparison.
   logic              stage_valid;
   logic [DATA_W-1:0] stage_data;

   logic [8:0]        test_idx;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [9:0]        pending;

   logic active, run_clear, hit, push_req, push_acc, pop, drop;
   logic all_checked, tmo_expire, tbl_we;

   assign active     = (state == S_ACTIVE);
   assign run_clear  = start && !active;
   assign hit        = mon_valid && mon_wen && (mon_addr == RESULT_ADDR);

   assign fifo_cnt   = wr_ptr - rd_ptr;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);

   // Results already compared, queued, or in the compare stage. Once this
   // reaches NUM_TESTS, further mailbox stores are surplus and silently ignored.
   assign pending    = 10'(test_idx) + 10'(fifo_cnt) + 10'(stage_valid);

   assign pop        = active && !fifo_empty;
   assign push_req   = active && hit && (pending < NUM_TESTS_10);
   // A full FIFO still accepts a push when a pop frees a slot on the same edge.
   assign push_acc   = push_req && (!fifo_full || pop);
   assign drop       = push_req && fifo_full && !pop;

   assign all_checked = (test_idx == NUM_TESTS_9);
   // Fires on the cycle whose edge brings the counter to TIMEOUT, so the
   // timeout flag and the move to DONE land on that same edge.
   assign tmo_expire  = active && !push_acc && (tmo_cnt == TMO_LAST);

   assign tbl_we = !active && ans_we && ({1'b0, ans_idx} < NUM_TESTS_9);

   // ---- FSM: state register ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_ACTIVE;
         S_ACTIVE: if (all_checked || tmo_expire) state_nxt = S_DONE;
         S_DONE:   if (start) state_nxt = S_ACTIVE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      busy = (state == S_ACTIVE);
      done = (state == S_DONE);
   end

   // NOTE: storage arrays carry no reset; their contents are only meaningful once written.
   always_ff @(posedge clock) begin
      if (tbl_we)   ans_tbl[ans_idx[IDX_W-1:0]]   <= ans_data;
      if (push_acc) fifo_mem[wr_ptr[PTR_W-1:0]]  <= mon_wdata;
   end

   // ---- Datapath: FIFO pointers, compare stage, counters, flags ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         stage_valid  <= 1'b0;
         stage_data   <= '0;
         test_idx     <= '0;
         tmo_cnt      <= '0;
         pass_count   <= '0;
         fail_count   <= '0;
         timeout      <= 1'b0;
         overflow     <= 1'b0;
         cmp_valid    <= 1'b0;
         cmp_pass     <= 1'b0;
         cmp_idx      <= '0;
         cmp_expected <= '0;
         cmp_actual   <= '0;
      end else if (run_clear) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         stage_valid <= 1'b0;
         test_idx    <= '0;
         tmo_cnt     <= '0;
         pass_count  <= '0;
         fail_count  <= '0;
         timeout     <= 1'b0;
         overflow    <= 1'b0;
         cmp_valid   <= 1'b0;
      end else begin
         cmp_valid <= stage_valid;
         if (stage_valid) begin
            cmp_idx      <= test_idx[7:0];
            cmp_expected <= ans_tbl[test_idx[IDX_W-1:0]];
            cmp_actual   <= stage_data;
            cmp_pass     <= (stage_data == ans_tbl[test_idx[IDX_W-1:0]]);
            if (stage_data == ans_tbl[test_idx[IDX_W-1:0]]) pass_count <= pass_count + 9'd1;
            else                                            fail_count <= fail_count + 9'd1;
            test_idx <= test_idx + 9'd1;
         end

         stage_valid <= pop;
         if (pop) begin
            stage_data <= fifo_mem[rd_ptr[PTR_W-1:0]];
            rd_ptr     <= rd_ptr + PTR_ONE;
         end

         if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (drop)     overflow <= 1'b1;

         if (active) begin
            if (push_acc)                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_ONE;
         end

         if (tmo_expire && !all_checked) timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_result_checker.sv
// ---------------------------------------------------------------------------
// tb_result_checker
//   Scoreboard bench for result_checker. Each mailbox store that the model
//   decides will be captured pushes its expected comparison into a queue; an
//   independent monitor pops and checks whenever cmp_valid pulses.
// ---------------------------------------------------------------------------
module tb_result_checker;

   localparam int          NT = 4;
   localparam int          FD = 4;
   localparam int          TO = 100;
   localparam logic [31:0] RA = 32'h800010d0;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        ans_we = 1'b0;
   logic [7:0]  ans_idx = '0;
   logic [31:0] ans_data = '0;
   logic        mon_valid = 1'b0;
   logic        mon_wen = 1'b0;
   logic [31:0] mon_addr = '0;
   logic [31:0] mon_wdata = '0;
   logic        busy, done, timeout, overflow;
   logic [8:0]  pass_count, fail_count;
   logic        cmp_valid, cmp_pass;
   logic [7:0]  cmp_idx;
   logic [31:0] cmp_expected, cmp_actual;

   result_checker #(
      .ADDR_W(32), .DATA_W(32), .RESULT_ADDR(RA),
      .NUM_TESTS(NT), .FIFO_DEPTH(FD), .TIMEOUT(TO)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .ans_we(ans_we), .ans_idx(ans_idx), .ans_data(ans_data),
      .mon_valid(mon_valid), .mon_wen(mon_wen), .mon_addr(mon_addr), .mon_wdata(mon_wdata),
      .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
      .pass_count(pass_count), .fail_count(fail_count),
      .cmp_valid(cmp_valid), .cmp_pass(cmp_pass), .cmp_idx(cmp_idx),
      .cmp_expected(cmp_expected), .cmp_actual(cmp_actual)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          idx;
      logic [31:0] exp_v;
      logic [31:0] act_v;
      logic        pass;
      int          cap_cyc;
      bit          chk_lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ans_m [NT];
   int n_checks = 0, n_fail = 0;
   int cap_n = 0, exp_pass = 0, exp_fail = 0, n_cmp = 0;
   int last_cmp_cyc = 0, start_cyc = 0, done_cyc = 0;
   bit model_active = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      ans_we   = 1'b1;
      ans_idx  = idx[7:0];
      ans_data = d;
      tick();
      ans_we = 1'b0;
      if (idx < NT) ans_m[idx] = d;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start        = 1'b0;
      start_cyc    = cyc;
      cap_n        = 0;
      exp_pass     = 0;
      exp_fail     = 0;
      model_active = 1'b1;
   endtask

   // One request cycle on the snooped port. The model captures the k-th
   // mailbox store of a run (k < NT) as result k.
   task automatic store(input logic [31:0] addr, input logic [31:0] d,
                        input logic wen, input logic vld, input bit chk_lat);
      exp_t e;
      mon_valid = vld;
      mon_wen   = wen;
      mon_addr  = addr;
      mon_wdata = d;
      tick();
      if (model_active && vld && wen && addr == RA && cap_n < NT) begin
         e.idx     = cap_n;
         e.exp_v   = ans_m[cap_n];
         e.act_v   = d;
         e.pass    = (d == ans_m[cap_n]);
         e.cap_cyc = cyc;
         e.chk_lat = chk_lat;
         sb.push_back(e);
         if (e.pass) exp_pass++;
         else        exp_fail++;
         cap_n++;
      end
      mon_valid = 1'b0;
      mon_wen   = 1'b0;
   endtask

   task automatic wait_done(input string name);
      done_cyc = -1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      if (done_cyc < 0) check({name, "_done_reached"}, 64'd0, 64'd1);
      model_active = 1'b0;
   endtask

   task automatic end_checks(input string name, input int p, input int f);
      check({name, "_pass_count"}, 64'(pass_count), 64'(p));
      check({name, "_fail_count"}, 64'(fail_count), 64'(f));
      check({name, "_overflow"},   64'(overflow),   64'd0);
      check({name, "_timeout"},    64'(timeout),    64'd0);
      check({name, "_busy"},       64'(busy),       64'd0);
      check({name, "_sb_drained"}, 64'(sb.size()),  64'd0);
   endtask

   // ---- Monitor: pops the scoreboard on each comparison pulse ----
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset && cmp_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_cmp", 64'(cmp_idx), 64'hFFFF);
            end else begin
               e = sb.pop_front();
               check("cmp_idx",      64'(cmp_idx),      64'(e.idx));
               check("cmp_expected", 64'(cmp_expected), 64'(e.exp_v));
               check("cmp_actual",   64'(cmp_actual),   64'(e.act_v));
               check("cmp_pass",     64'(cmp_pass),     64'(e.pass));
               if (e.chk_lat) check("cmp_latency", 64'(cyc - e.cap_cyc), 64'd2);
            end
            n_cmp++;
            last_cmp_cyc = cyc;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int base, tcyc;
      logic [31:0] d;

      // ---- Reset state ----
      idle(3);
      check("rst_busy",     64'(busy),       64'd0);
      check("rst_done",     64'(done),       64'd0);
      check("rst_timeout",  64'(timeout),    64'd0);
      check("rst_overflow", 64'(overflow),   64'd0);
      check("rst_counts",   64'({pass_count, fail_count}), 64'd0);
      check("rst_cmp",      64'({cmp_valid, cmp_pass, cmp_idx}), 64'd0);
      reset = 1'b1;
      idle(2);

      // ---- 1: all-pass run, spaced stores, latency and done timing ----
      load(0, 32'd0); load(1, 32'd1); load(2, 32'd1); load(3, 32'd2);
      do_start();
      check("t1_busy", 64'(busy), 64'd1);
      for (int i = 0; i < NT; i++) begin
         if (i > 0) idle(4);
         store(RA, ans_m[i], 1'b1, 1'b1, 1'b1);
      end
      wait_done("t1");
      check("t1_done_after_last_cmp", 64'(done_cyc - last_cmp_cyc), 64'd1);
      end_checks("t1", 4, 0);

      // ---- 2: one mismatching result, restarted from DONE ----
      do_start();
      for (int i = 0; i < NT; i++) begin
         if (i > 0) idle(4);
         store(RA, (i == 2) ? 32'hDEADBEEF : ans_m[i], 1'b1, 1'b1, 1'b1);
      end
      wait_done("t2");
      end_checks("t2", 3, 1);

      // ---- 3: six back-to-back stores right after start ----
      do_start();
      for (int i = 0; i < 6; i++) store(RA, (i < NT) ? ans_m[i] : 32'h1234, 1'b1, 1'b1, 1'b0);
      wait_done("t3");
      end_checks("t3", 4, 0);

      // ---- 4: only loads to the mailbox and stores elsewhere -> timeout ----
      do_start();
      tcyc = -1;
      for (int i = 0; i < TO + 20; i++) begin
         if (i % 2 == 0) store(RA,        $urandom, 1'b0, 1'b1, 1'b0);
         else            store(RA + 32'd4, $urandom, 1'b1, 1'b1, 1'b0);
         if (timeout) begin
            tcyc = cyc;
            break;
         end
      end
      model_active = 1'b0;
      check("t4_timeout_cycles", 64'(tcyc - start_cyc), 64'(TO));
      check("t4_done",       64'(done),       64'd1);
      check("t4_pass_count", 64'(pass_count), 64'd0);
      check("t4_fail_count", 64'(fail_count), 64'd0);
      check("t4_no_capture", 64'(sb.size()),  64'd0);

      // ---- 5: reset mid-run after two comparisons, then a clean run ----
      do_start();
      check("t5_timeout_cleared", 64'(timeout), 64'd0);
      base = n_cmp;
      store(RA, ans_m[0], 1'b1, 1'b1, 1'b0);
      idle(2);
      store(RA, 32'h0BAD_0001, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20 && n_cmp < base + 2; i++) tick();
      check("t5_two_cmps", 64'(n_cmp - base), 64'd2);
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_state",  64'({busy, done, timeout, overflow}), 64'd0);
      check("t5_rst_counts", 64'({pass_count, fail_count}), 64'd0);
      check("t5_rst_cmp",    64'({cmp_valid, cmp_pass, cmp_idx}), 64'd0);
      check("t5_rst_data",   64'({cmp_expected, cmp_actual}), 64'd0);
      sb.delete();
      model_active = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(1);
      load(0, 32'd10); load(1, 32'd20); load(2, 32'd30); load(3, 32'd40);
      do_start();
      for (int i = 0; i < NT; i++) begin
         idle(1);
         store(RA, ans_m[i], 1'b1, 1'b1, 1'b1);
      end
      wait_done("t5");
      end_checks("t5", 4, 0);

      // ---- 6: table writes while ACTIVE are ignored ----
      do_start();
      ans_we   = 1'b1;
      ans_idx  = 8'd0;
      ans_data = 32'h55;
      for (int i = 0; i < NT; i++) store(RA, ans_m[i], 1'b1, 1'b1, 1'b0);
      ans_we = 1'b0;
      wait_done("t6");
      end_checks("t6", 4, 0);

      // Writes in DONE take effect; an out-of-range index is dropped.
      load(0, 32'h7);
      load(5, 32'h0BAD);

      // ---- 7: randomized runs with noise traffic ----
      for (int it = 0; it < 4; it++) begin
         if (it > 0) begin
            for (int k = 0; k < NT; k++)
               if ($urandom_range(1, 0) == 1) load(k, $urandom);
         end
         do_start();
         for (int r = 0; r < NT; r++) begin
            for (int g = 0; g < $urandom_range(3, 0); g++) begin
               case ($urandom_range(2, 0))
                  0:       store(RA,         $urandom, 1'b0, 1'b1, 1'b0);
                  1:       store(RA + 32'd4, $urandom, 1'b1, 1'b1, 1'b0);
                  default: store(RA,         $urandom, 1'b1, 1'b0, 1'b0);
               endcase
            end
            d = ($urandom_range(1, 0) == 1) ? ans_m[r] : $urandom;
            store(RA, d, 1'b1, 1'b1, 1'b0);
         end
         wait_done("t7");
         end_checks("t7", exp_pass, exp_fail);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
